// File: rtl/core_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Strobes are combinational; halt/trap status and the retired-instruction counter are registered.
`timescale 1ns/1ps
module core_ctrl_fsm #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [5:0] ILLEGAL_ID  = 6'd63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [4:0]  rd,
    input  logic [5:0]  instr_id,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur_state;
    logic [7:0] tmo_cnt;

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_system, is_legal_op, is_illegal, tmo_hit;
    logic [1:0] jump_sel;

    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_branch   = (opcode == OP_BRANCH);
    assign is_jal      = (opcode == OP_JAL);
    assign is_jalr     = (opcode == OP_JALR);
    assign is_system   = (opcode == OP_SYSTEM);
    assign is_legal_op = is_load || is_store || is_branch || is_jal || is_jalr || is_system ||
                         (opcode == OP_REG) || (opcode == OP_IMM) ||
                         (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_illegal  = (instr_id == ILLEGAL_ID) || !is_legal_op;
    assign jump_sel    = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign state       = cur_state;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        // Gating with rst_n keeps every strobe low for the whole reset pulse, including imem_req.
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    imem_req = run;
                    ir_we    = run && imem_ready;
                end
                S_EXEC: begin
                    alu_en = 1'b1;
                    pc_sel = (is_branch && branch_taken) ? 2'd1 : jump_sel;
                    pc_we  = is_branch && !is_illegal;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = is_store && dmem_ready;
                end
                S_WB: begin
                    reg_we = (rd != 5'd0);
                    pc_we  = 1'b1;
                    pc_sel = jump_sel;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= S_FETCH;
            tmo_cnt    <= 8'd0;
            instret    <= 32'd0;
            trap_cause <= 2'd0;
            halted     <= 1'b0;
            trap       <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (!run || imem_ready) begin
                        tmo_cnt <= 8'd0;
                        if (run) cur_state <= S_DECODE;
                    end else if (tmo_hit) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd3;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DECODE: cur_state <= S_EXEC;
                S_EXEC: begin
                    tmo_cnt <= 8'd0;
                    if (is_illegal) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                    end else if (is_load || is_store) begin
                        cur_state <= S_MEM;
                    end else if (is_branch) begin
                        instret   <= instret + 32'd1;
                        cur_state <= S_FETCH;
                    end else if (is_system && func3 == 3'd0) begin
                        instret   <= instret + 32'd1;
                        halted    <= 1'b1;
                        cur_state <= S_HALT;
                    end else begin
                        cur_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        tmo_cnt <= 8'd0;
                        if (is_store) begin
                            instret   <= instret + 32'd1;
                            cur_state <= S_FETCH;
                        end else begin
                            cur_state <= S_WB;
                        end
                    end else if (tmo_hit) begin
                        cur_state  <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd2;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    instret   <= instret + 32'd1;
                    cur_state <= S_FETCH;
                end
                default: cur_state <= cur_state;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: stimulus queues expected strobe cycles, a negedge monitor
// pops and compares whenever the DUT asserts any strobe; status outputs are checked directly.
`timescale 1ns/1ps
module tb_core_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, branch_taken, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [5:0]  instr_id;
    logic        imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we, pc_we;
    logic [1:0]  pc_sel;
    logic        halted, trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    core_ctrl_fsm #(.MEM_TIMEOUT(16), .ILLEGAL_ID(6'd63)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3), .rd(rd),
        .instr_id(instr_id), .branch_taken(branch_taken), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    // Flag order: imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we, pc_we.
    typedef struct packed {
        logic [2:0] st;
        logic [6:0] flags;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;

    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] flags_now();
        return {imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we, pc_we};
    endfunction

    always @(negedge clk) begin
        if (ir_we || alu_en || dmem_req || reg_we || pc_we) begin
            exp_t act;
            act = '{st: state, flags: flags_now(), sel: pc_sel};
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(act.flags), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("strobes@cyc%0d", cyc_n), 32'(act), 32'(e));
            end
        end
    end

    task automatic push(input logic [2:0] st, input logic [6:0] flags, input logic [1:0] sel);
        exp_q.push_back('{st: st, flags: flags, sel: sel});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                             input logic [5:0] id);
        opcode = op; func3 = f3; rd = r; instr_id = id;
    endtask

    task automatic idle_inputs();
        run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", {flags_now(), pc_sel, halted, trap, trap_cause}, 32'd0);
        check("rst_instret", instret, 32'd0);
        cyc();
        rst_n = 1'b1;
    endtask

    // FETCH with instruction ready at once, then DECODE; run drops after the fetch.
    task automatic fetch();
        run = 1'b1; imem_ready = 1'b1;
        push(3'd0, 7'b1100000, 2'd0);
        cyc();
        run = 1'b0; imem_ready = 1'b0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        idle_inputs();
        set_instr(7'd0, 3'd0, 5'd0, 6'd0);
        rst_n = 1'b1;
        #3;
        do_reset();
        cyc(); cyc();
        check("idle_no_imem_req", {31'd0, imem_req}, 32'd0);

        // ADD rd=5
        c0 = cyc_n;
        set_instr(7'b0110011, 3'd0, 5'd5, 6'd1);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        push(3'd4, 7'b0000011, 2'd0); cyc();
        check("add_cycles", 32'(cyc_n - c0), 32'd4);
        check("add_instret", instret, 32'd1);
        check("add_state", 32'(state), 32'd0);

        // LW rd=3, dmem_ready on third MEM cycle
        c0 = cyc_n;
        set_instr(7'b0000011, 3'd2, 5'd3, 6'd2);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        push(3'd3, 7'b0001000, 2'd0); cyc();
        push(3'd3, 7'b0001000, 2'd0); cyc();
        dmem_ready = 1'b1;
        push(3'd3, 7'b0001000, 2'd0); cyc();
        dmem_ready = 1'b0;
        push(3'd4, 7'b0000011, 2'd0); cyc();
        check("lw_cycles", 32'(cyc_n - c0), 32'd7);
        check("lw_instret", instret, 32'd2);

        // BEQ taken, then not taken
        set_instr(7'b1100011, 3'd0, 5'd0, 6'd3);
        branch_taken = 1'b1;
        fetch();
        push(3'd2, 7'b0010001, 2'd1); cyc();
        check("beq_t_instret", instret, 32'd3);
        check("beq_t_state", 32'(state), 32'd0);
        branch_taken = 1'b0;
        fetch();
        push(3'd2, 7'b0010001, 2'd0); cyc();
        check("beq_nt_instret", instret, 32'd4);

        // JALR rd=0, JAL rd=1
        set_instr(7'b1100111, 3'd0, 5'd0, 6'd4);
        fetch();
        push(3'd2, 7'b0010000, 2'd2); cyc();
        push(3'd4, 7'b0000001, 2'd2); cyc();
        check("jalr_instret", instret, 32'd5);
        set_instr(7'b1101111, 3'd0, 5'd1, 6'd5);
        fetch();
        push(3'd2, 7'b0010000, 2'd1); cyc();
        push(3'd4, 7'b0000011, 2'd1); cyc();
        check("jal_instret", instret, 32'd6);

        // SW, dmem_ready on second MEM cycle
        set_instr(7'b0100011, 3'd2, 5'd0, 6'd6);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        push(3'd3, 7'b0001100, 2'd0); cyc();
        dmem_ready = 1'b1;
        push(3'd3, 7'b0001101, 2'd0); cyc();
        dmem_ready = 1'b0;
        check("sw_instret", instret, 32'd7);
        check("sw_state", 32'(state), 32'd0);

        // ECALL/EBREAK -> HALT, then input activity must produce nothing
        set_instr(7'b1110011, 3'd0, 5'd0, 6'd7);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        check("halt_state", 32'(state), 32'd5);
        check("halt_status", {30'd0, halted, trap}, 32'h2);
        check("halt_instret", instret, 32'd8);
        run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) cyc();
        check("halt_quiet", 32'(flags_now()), 32'd0);
        check("halt_hold", {instret[28:0], state}, {29'd8, 3'd5});

        // SW with dmem_ready never arriving -> TRAP after 16 MEM cycles
        do_reset();
        set_instr(7'b0100011, 3'd2, 5'd0, 6'd6);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        for (int i = 0; i < 16; i++) begin
            push(3'd3, 7'b0001100, 2'd0);
            cyc();
        end
        check("dtmo_state", 32'(state), 32'd6);
        check("dtmo_status", {28'd0, halted, trap, trap_cause}, 32'b0110);
        check("dtmo_instret", instret, 32'd0);
        check("dtmo_dmem_req", {31'd0, dmem_req}, 32'd0);

        // Illegal by instr_id, then by opcode
        do_reset();
        set_instr(7'b0110011, 3'd0, 5'd5, 6'd63);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        check("ill_id_state", 32'(state), 32'd6);
        check("ill_id_cause", {29'd0, trap, trap_cause}, 32'b101);
        do_reset();
        set_instr(7'b0000000, 3'd0, 5'd5, 6'd4);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        check("ill_op_cause", {29'd0, trap, trap_cause}, 32'b101);

        // imem never ready -> TRAP on the 16th waiting cycle
        do_reset();
        run = 1'b1;
        repeat (15) cyc();
        check("itmo_wait_state", {30'd0, imem_req, state == 3'd0}, 32'b11);
        cyc();
        check("itmo_state", 32'(state), 32'd6);
        check("itmo_cause", {29'd0, trap, trap_cause}, 32'b111);

        // Reset asserted mid-MEM drops strobes immediately
        do_reset();
        set_instr(7'b0100011, 3'd2, 5'd0, 6'd6);
        fetch();
        push(3'd2, 7'b0010000, 2'd0); cyc();
        push(3'd3, 7'b0001100, 2'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {flags_now(), pc_sel, state}, 32'd0);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
